// File: rtl/noise_cfg_sched_if.sv
// Config-frame scheduler bus: SPI frame input side,
// per-channel command/ack side and status flags.
interface noise_cfg_sched_if;
  logic        frame_valid;
  logic [39:0] frame_data;
  logic        sched_en;
  logic        err_clr;
  logic [3:0]  cfg_ack;
  logic [3:0]  cfg_valid;
  logic        cfg_type;
  logic [22:0] cfg_data;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        ovf_err;
  logic        tmo_err;

  modport master (
    output frame_valid,
    output frame_data,
    output sched_en,
    output err_clr,
    output cfg_ack,
    input  cfg_valid,
    input  cfg_type,
    input  cfg_data,
    input  fifo_level,
    input  busy,
    input  ovf_err,
    input  tmo_err
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  sched_en,
    input  err_clr,
    input  cfg_ack,
    output cfg_valid,
    output cfg_type,
    output cfg_data,
    output fifo_level,
    output busy,
    output ovf_err,
    output tmo_err
  );
endinterface

// File: rtl/noise_cfg_sched.sv
// Queues SPI config frames and issues them one at a time
// to noise channels, holding each until ack or timeout.
module noise_cfg_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  noise_cfg_sched_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]    DEPTH    = 5'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_DRIVE
  } state_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic        typ;
    logic [22:0] pay;
  } ent_t;

  state_t        r_state;
  state_t        w_state_nxt;

  ent_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_level;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ch;
  logic [3:0]    r_valid;
  logic          r_type;
  logic [22:0]   r_data;
  logic          r_ovf;
  logic          r_tmo;

  ent_t          w_head;
  ent_t          w_in;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_tmo_set;
  logic          w_ack_hit;
  logic          w_tmo_hit;
  logic          w_unused;

  assign w_in.ch  = bus.frame_data[39:38];
  assign w_in.typ = bus.frame_data[37];
  assign w_in.pay = bus.frame_data[22:0];
  assign w_unused = ^bus.frame_data[36:23];

  assign w_head    = r_mem[r_rptr];
  assign w_full    = (r_level == DEPTH);
  assign w_empty   = (r_level == 5'd0);
  assign w_ack_hit = bus.cfg_ack[r_ch];
  assign w_tmo_hit = (r_cnt == TMO_LAST);

  // A pop on the same edge frees the slot a full-queue push needs
  assign w_push    = bus.frame_valid & (~w_full | w_pop);
  assign w_ovf_set = bus.frame_valid & w_full & ~w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tmo_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && bus.sched_en) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (w_ack_hit) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ch    <= 2'd0;
      r_valid <= 4'd0;
      r_type  <= 1'b0;
      r_data  <= 23'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_cnt   <= '0;
        r_ch    <= w_head.ch;
        r_valid <= 4'b0001 << w_head.ch;
        r_type  <= w_head.typ;
        r_data  <= w_head.typ ? w_head.pay
                              : {6'd0, w_head.pay[16:0]};
      end else if (r_state == S_DRIVE) begin
        if (w_state_nxt == S_IDLE) begin
          r_valid <= 4'd0;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 5'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // New error events take priority over a same-edge clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_tmo <= w_tmo_set | (r_tmo & ~bus.err_clr);
    end
  end

  assign bus.cfg_valid  = r_valid;
  assign bus.cfg_type   = r_type;
  assign bus.cfg_data   = r_data;
  assign bus.fifo_level = r_level;
  assign bus.busy       = (r_state != S_IDLE) | ~w_empty;
  assign bus.ovf_err    = r_ovf;
  assign bus.tmo_err    = r_tmo;

endmodule

// File: doc/noise_cfg_sched.md
NOISE_CFG_SCHED -- requirements
Module: noise_cfg_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 65535, max DRIVE cycles awaiting ack before abort.
REQ-003 sys_clk  in  1  system clock; all logic on rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 frame_valid  in  1  one-cycle pulse: new 40-bit SPI config frame available.
REQ-006 frame_data  in  40  frame: [39:38] channel, [37] type (0=freq_div, 1=lfsr seed), [36:23] ignored, [22:0] payload.
REQ-007 sched_en  in  1  high: FSM may issue commands; low: queue only.
REQ-008 err_clr  in  1  one-cycle pulse clearing sticky error flags.
REQ-009 cfg_ack  in  4  per-channel acknowledge, raised by a noise channel at its divider-wrap boundary.
REQ-010 cfg_valid  out  4  one-hot per-channel command strobe, held until ack or abort.
REQ-011 cfg_type  out  1  type of the issued command.
REQ-012 cfg_data  out  23  payload; freq_div uses [16:0], [22:17] zero-forced for type 0.
REQ-013 fifo_level  out  5  current queue occupancy, 0..FIFO_DEPTH.
REQ-014 busy  out  1  high while FSM is not IDLE or queue is non-empty.
REQ-015 ovf_err  out  1  sticky: frame dropped on full queue.
REQ-016 tmo_err  out  1  sticky: command aborted by timeout.

Function
REQ-017 SHALL store frames in a FIFO_DEPTH-entry in-order FIFO (channel, type, payload); push on the edge where frame_valid is sampled high.
REQ-018 Push on full queue with no same-edge pop SHALL discard the frame and set ovf_err; same-edge push and pop on full SHALL accept and leave level at FIFO_DEPTH.
REQ-019 Read/write pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push+pop SHALL leave fifo_level unchanged.
REQ-020 FSM states: IDLE, DRIVE.
REQ-021 IDLE -> DRIVE when queue non-empty and sched_en high: pop head into holding register, clear timeout counter, assert cfg_valid[channel].
REQ-022 Latency: frame_valid sampled at edge E0 with empty queue, idle FSM, sched_en high -> cfg_valid registered high after edge E1 (2 edges).
REQ-023 cfg_valid, cfg_type, cfg_data SHALL be registered and stable throughout DRIVE.
REQ-024 DRIVE -> IDLE when cfg_ack[active channel] sampled high; cfg_valid low after that edge; ack on other channels SHALL be ignored.
REQ-025 Timeout counter SHALL increment each DRIVE cycle; reaching TIMEOUT without ack -> drop command, set tmo_err, return IDLE.
REQ-026 Ack and timeout on same edge: ack wins; tmo_err not set.
REQ-027 One idle cycle SHALL separate consecutive commands (minimum 2 cycles per command).
REQ-028 sched_en low SHALL not abort a command in DRIVE; it blocks only the next IDLE->DRIVE transition.
REQ-029 err_clr SHALL clear ovf_err and tmo_err; a new error event on the same edge SHALL win (flag remains set).
REQ-030 In IDLE, cfg_type and cfg_data SHALL hold last issued values; cfg_valid SHALL be 0.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, empty queue (fifo_level=0), cfg_valid=0, cfg_type=0, cfg_data=0, ovf_err=0, tmo_err=0, busy=0, timeout counter=0.
REQ-032 Reset mid-DRIVE SHALL discard the in-flight command and all queued frames; no cfg_valid after release until a new frame arrives.
REQ-033 Reset release SHALL be synchronous to sys_clk; first frame accepted on the first edge after deassertion.

Verification
REQ-034 Frame ch=2, type=0, payload=0x0032C8 -> cfg_valid=4'b0100, cfg_data=0x0032C8 two edges later; ack ch2 after 10 cycles -> cfg_valid=0, busy=0.
REQ-035 sched_en=0, push 5 frames, FIFO_DEPTH=4 -> fifo_level=4, ovf_err=1; sched_en=1 -> first 4 frames issued in order, 5th never issued.
REQ-036 No ack, TIMEOUT=16 -> cfg_valid drops after 16 DRIVE cycles, tmo_err=1; err_clr -> tmo_err=0.
REQ-037 Ack on channel 1 while driving channel 3 -> ignored, cfg_valid stays 4'b1000; ack and timeout same edge -> tmo_err stays 0.
REQ-038 Reset asserted mid-DRIVE with 3 queued -> all outputs zero asynchronously; after release no cfg_valid activity.
REQ-039 Push on full with same-edge pop -> accepted, fifo_level=4, ovf_err=0.
